// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the datapath bus gate arbiter.
package bus_arb_pkg;

  // Requester count, tied to the width of the one-hot bus mux select.
  localparam int N_REQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  // One-hot gate selects, bit order matches the bus mux inputs.
  localparam logic [N_REQ-1:0] GATE_PC     = 4'b0001;
  localparam logic [N_REQ-1:0] GATE_MDR    = 4'b0010;
  localparam logic [N_REQ-1:0] GATE_ALU    = 4'b0100;
  localparam logic [N_REQ-1:0] GATE_MARMUX = 4'b1000;

  // Binary index of a one-hot select; zero or malformed input maps to 0.
  function automatic logic [1:0] onehot2idx(input logic [N_REQ-1:0] oh);
    logic [1:0] idx;
    case (oh)
      GATE_PC:     idx = 2'd0;
      GATE_MDR:    idx = 2'd1;
      GATE_ALU:    idx = 2'd2;
      GATE_MARMUX: idx = 2'd3;
      default:     idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first masked request at or after ptr, mod 4.
module rr_pick
  import bus_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  input  logic [N_REQ-1:0] mask,
  output logic             valid,
  output logic [1:0]       idx
);

  logic [N_REQ-1:0] w_eff;
  logic [N_REQ-1:0] w_rot;
  logic [1:0]       w_off;

  // Rotate the eligible requests so that bit 0 is the current top priority.
  always_comb begin
    w_eff = req & mask;
    case (ptr)
      2'd0:    w_rot = w_eff;
      2'd1:    w_rot = {w_eff[0],   w_eff[3:1]};
      2'd2:    w_rot = {w_eff[1:0], w_eff[3:2]};
      2'd3:    w_rot = {w_eff[2:0], w_eff[3]};
      default: w_rot = w_eff;
    endcase
  end

  // Lowest set bit of the rotated vector, mapped back to an absolute index.
  always_comb begin
    valid = |w_eff;
    casez (w_rot)
      4'b???1: w_off = 2'd0;
      4'b??10: w_off = 2'd1;
      4'b?100: w_off = 2'd2;
      4'b1000: w_off = 2'd3;
      default: w_off = 2'd0;
    endcase
    idx = ptr + w_off;
  end

endmodule

// File: rtl/bus_gate_arbiter.sv
// Round-robin owner sequencer for the shared 16-bit datapath bus.
// Emits a registered one-hot gate select with bounded hold time and an
// optional idle turnaround cycle between different owners.
module bus_gate_arbiter
  import bus_arb_pkg::*;
#(
  parameter int MAX_HOLD   = 8,
  parameter int TURNAROUND = 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gate_sel,
  output logic [1:0]       owner_id,
  output logic             bus_busy,
  output logic             preempt
);

  localparam int              HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0]   HOLD_ONE = HW'(1);

  arb_state_t       r_state;
  logic [1:0]       r_rr_ptr;
  logic [HW-1:0]    r_hold_cnt;
  logic [N_REQ-1:0] r_gate_sel;
  logic [1:0]       r_owner_id;
  logic             r_bus_busy;
  logic             r_preempt;

  logic [1:0]       w_owner;
  logic             w_own_req;
  logic             w_others;
  logic             w_at_max;
  logic             w_keep;
  logic             w_preempt;
  logic [1:0]       w_ptr;
  logic [N_REQ-1:0] w_mask;
  logic             w_valid;
  logic [1:0]       w_idx;

  // Owner status and arbitration inputs; while granted, the picker looks
  // ahead from owner+1 and skips the owner so a forced handoff goes elsewhere.
  always_comb begin
    w_owner   = onehot2idx(r_gate_sel);
    w_own_req = |(req & r_gate_sel);
    w_others  = |(req & ~r_gate_sel);
    w_at_max  = (r_hold_cnt == HOLD_MAX);
    w_keep    = w_own_req && (!w_at_max || !w_others);
    w_preempt = w_own_req && w_at_max && w_others;
    if (r_state == GRANT) begin
      w_ptr  = w_owner + 2'd1;
      w_mask = ~r_gate_sel;
    end else begin
      w_ptr  = r_rr_ptr;
      w_mask = {N_REQ{1'b1}};
    end
  end

  rr_pick u_rr_pick (
    .req   (req),
    .ptr   (w_ptr),
    .mask  (w_mask),
    .valid (w_valid),
    .idx   (w_idx)
  );

  // Ownership FSM; every output is registered together with the state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= IDLE;
      r_rr_ptr   <= 2'd0;
      r_hold_cnt <= {HW{1'b0}};
      r_gate_sel <= {N_REQ{1'b0}};
      r_owner_id <= 2'd0;
      r_bus_busy <= 1'b0;
      r_preempt  <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        IDLE, TURN: begin
          if (w_valid) begin
            r_state    <= GRANT;
            r_gate_sel <= 4'b0001 << w_idx;
            r_owner_id <= w_idx;
            r_bus_busy <= 1'b1;
            r_hold_cnt <= HOLD_ONE;
          end else begin
            r_state    <= IDLE;
            r_gate_sel <= {N_REQ{1'b0}};
            r_owner_id <= 2'd0;
            r_bus_busy <= 1'b0;
            r_hold_cnt <= {HW{1'b0}};
          end
        end
        GRANT: begin
          if (w_keep) begin
            // Saturate so a sole requester can hold the bus indefinitely.
            if (!w_at_max) begin
              r_hold_cnt <= r_hold_cnt + HOLD_ONE;
            end else begin
              r_hold_cnt <= r_hold_cnt;
            end
          end else begin
            r_preempt <= w_preempt;
            r_rr_ptr  <= w_owner + 2'd1;
            if (TURNAROUND != 0) begin
              r_state    <= TURN;
              r_gate_sel <= {N_REQ{1'b0}};
              r_owner_id <= 2'd0;
              r_bus_busy <= 1'b0;
              r_hold_cnt <= {HW{1'b0}};
            end else if (w_valid) begin
              r_state    <= GRANT;
              r_gate_sel <= 4'b0001 << w_idx;
              r_owner_id <= w_idx;
              r_bus_busy <= 1'b1;
              r_hold_cnt <= HOLD_ONE;
            end else begin
              r_state    <= IDLE;
              r_gate_sel <= {N_REQ{1'b0}};
              r_owner_id <= 2'd0;
              r_bus_busy <= 1'b0;
              r_hold_cnt <= {HW{1'b0}};
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_gate_sel <= {N_REQ{1'b0}};
          r_owner_id <= 2'd0;
          r_bus_busy <= 1'b0;
          r_hold_cnt <= {HW{1'b0}};
        end
      endcase
    end
  end

  assign gate_sel = r_gate_sel;
  assign owner_id = r_owner_id;
  assign bus_busy = r_bus_busy;
  assign preempt  = r_preempt;

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Directed bench for bus_gate_arbiter: one instance with a turnaround cycle,
// one switching owners directly.
module tb_bus_gate_arbiter;
  import bus_arb_pkg::*;

  logic       Clk     = 1'b0;
  logic       Reset_n = 1'b0;
  logic [3:0] req_a   = 4'b0000;
  logic [3:0] req_b   = 4'b0000;
  logic [3:0] gate_a, gate_b;
  logic [1:0] own_a, own_b;
  logic       busy_a, busy_b, pre_a, pre_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  bus_gate_arbiter #(.MAX_HOLD(8), .TURNAROUND(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req(req_a),
    .gate_sel(gate_a), .owner_id(own_a), .bus_busy(busy_a), .preempt(pre_a)
  );

  bus_gate_arbiter #(.MAX_HOLD(8), .TURNAROUND(0)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .req(req_b),
    .gate_sel(gate_b), .owner_id(own_b), .bus_busy(busy_b), .preempt(pre_b)
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset;
    Reset_n = 1'b0;
    req_a   = 4'b0000;
    req_b   = 4'b0000;
    tick();
    tick();
    Reset_n = 1'b1;
  endtask

  task automatic test_reset;
    #1;
    n_tests++;
    if (gate_a !== 4'b0000 || own_a !== 2'd0 || busy_a !== 1'b0 || pre_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a: gate_sel=%b owner_id=%0d bus_busy=%b preempt=%b, expected 0000/0/0/0",
               gate_a, own_a, busy_a, pre_a);
    end
    n_tests++;
    if (gate_b !== 4'b0000 || own_b !== 2'd0 || busy_b !== 1'b0 || pre_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_b: gate_sel=%b owner_id=%0d bus_busy=%b preempt=%b, expected 0000/0/0/0",
               gate_b, own_b, busy_b, pre_b);
    end
  endtask

  task automatic test_single_grant;
    do_reset();
    req_a = 4'b0100;
    tick();
    n_tests++;
    if (gate_a !== 4'b0100 || own_a !== 2'd2 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: gate_sel=%b owner_id=%0d bus_busy=%b, expected 0100/2/1",
               gate_a, own_a, busy_a);
    end
    req_a = 4'b0000;
    tick();
    n_tests++;
    if (gate_a !== 4'b0000 || busy_a !== 1'b0 || pre_a !== 1'b0 || dut.r_state !== TURN) begin
      n_fail++;
      $display("FAIL single_turn: gate_sel=%b bus_busy=%b preempt=%b state=%0d, expected 0000/0/0/TURN",
               gate_a, busy_a, pre_a, dut.r_state);
    end
    tick();
    n_tests++;
    if (gate_a !== 4'b0000 || dut.r_state !== IDLE) begin
      n_fail++;
      $display("FAIL single_idle: gate_sel=%b state=%0d, expected 0000/IDLE", gate_a, dut.r_state);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g;
    int g;
    do_reset();
    req_a = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      g     = n % 4;
      exp_g = 4'b0001 << g;
      for (int c = 0; c < 8; c++) begin
        tick();
        n_tests++;
        if (gate_a !== exp_g || own_a !== 2'(g) || pre_a !== 1'b0) begin
          n_fail++;
          $display("FAIL rr_hold grant %0d cycle %0d: gate_sel=%b owner_id=%0d preempt=%b, expected %b/%0d/0",
                   n, c, gate_a, own_a, pre_a, exp_g, g);
        end
      end
      if (n < 4) begin
        tick();
        n_tests++;
        if (gate_a !== 4'b0000 || busy_a !== 1'b0 || pre_a !== 1'b1) begin
          n_fail++;
          $display("FAIL rr_handoff %0d: gate_sel=%b bus_busy=%b preempt=%b, expected 0000/0/1",
                   n, gate_a, busy_a, pre_a);
        end
      end
    end
    req_a = 4'b0000;
  endtask

  task automatic test_sole_requester;
    do_reset();
    req_a = 4'b0010;
    for (int c = 0; c < 50; c++) begin
      tick();
      n_tests++;
      if (gate_a !== 4'b0010 || pre_a !== 1'b0) begin
        n_fail++;
        $display("FAIL sole cycle %0d: gate_sel=%b preempt=%b, expected 0010/0", c, gate_a, pre_a);
      end
    end
    n_tests++;
    if (dut.r_hold_cnt !== 4'd8) begin
      n_fail++;
      $display("FAIL sole_hold: hold_cnt=%0d, expected 8", dut.r_hold_cnt);
    end
    req_a = 4'b0000;
  endtask

  task automatic test_voluntary_release;
    do_reset();
    req_a = 4'b0001;
    tick();
    req_a = 4'b1001;
    tick();
    tick();
    n_tests++;
    if (gate_a !== 4'b0001 || dut.r_hold_cnt !== 4'd3) begin
      n_fail++;
      $display("FAIL vol_hold: gate_sel=%b hold_cnt=%0d, expected 0001/3", gate_a, dut.r_hold_cnt);
    end
    req_a = 4'b1000;
    tick();
    n_tests++;
    if (gate_a !== 4'b0000 || pre_a !== 1'b0) begin
      n_fail++;
      $display("FAIL vol_release: gate_sel=%b preempt=%b, expected 0000/0", gate_a, pre_a);
    end
    tick();
    n_tests++;
    if (gate_a !== 4'b1000 || own_a !== 2'd3 || pre_a !== 1'b0) begin
      n_fail++;
      $display("FAIL vol_next: gate_sel=%b owner_id=%0d preempt=%b, expected 1000/3/0",
               gate_a, own_a, pre_a);
    end
    req_a = 4'b0000;
  endtask

  task automatic test_no_turnaround;
    do_reset();
    req_b = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_tests++;
      if (gate_b !== 4'b0001 || pre_b !== 1'b0) begin
        n_fail++;
        $display("FAIL nt_first cycle %0d: gate_sel=%b preempt=%b, expected 0001/0", c, gate_b, pre_b);
      end
    end
    tick();
    n_tests++;
    if (gate_b !== 4'b0010 || own_b !== 2'd1 || pre_b !== 1'b1) begin
      n_fail++;
      $display("FAIL nt_switch: gate_sel=%b owner_id=%0d preempt=%b, expected 0010/1/1",
               gate_b, own_b, pre_b);
    end
    for (int c = 1; c < 8; c++) begin
      tick();
      n_tests++;
      if (gate_b !== 4'b0010 || pre_b !== 1'b0) begin
        n_fail++;
        $display("FAIL nt_second cycle %0d: gate_sel=%b preempt=%b, expected 0010/0", c, gate_b, pre_b);
      end
    end
    tick();
    n_tests++;
    if (gate_b !== 4'b0001 || own_b !== 2'd0 || pre_b !== 1'b1) begin
      n_fail++;
      $display("FAIL nt_switch_back: gate_sel=%b owner_id=%0d preempt=%b, expected 0001/0/1",
               gate_b, own_b, pre_b);
    end
    req_b = 4'b0011;
    req_b = 4'b0000;
    tick();
    n_tests++;
    if (gate_b !== 4'b0000 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL nt_idle: gate_sel=%b bus_busy=%b, expected 0000/0", gate_b, busy_b);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    req_a = 4'b1000;
    tick();
    n_tests++;
    if (gate_a !== 4'b1000 || own_a !== 2'd3) begin
      n_fail++;
      $display("FAIL ar_grant: gate_sel=%b owner_id=%0d, expected 1000/3", gate_a, own_a);
    end
    tick();
    tick();
    #3;
    Reset_n = 1'b0;
    #1;
    n_tests++;
    if (gate_a !== 4'b0000 || own_a !== 2'd0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_immediate: gate_sel=%b owner_id=%0d bus_busy=%b, expected 0000/0/0",
               gate_a, own_a, busy_a);
    end
    req_a = 4'b1001;
    #1;
    Reset_n = 1'b1;
    #1;
    n_tests++;
    if (gate_a !== 4'b0000) begin
      n_fail++;
      $display("FAIL ar_no_early_grant: gate_sel=%b, expected 0000", gate_a);
    end
    tick();
    n_tests++;
    if (gate_a !== 4'b0001 || own_a !== 2'd0 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_regrant: gate_sel=%b owner_id=%0d bus_busy=%b, expected 0001/0/1",
               gate_a, own_a, busy_a);
    end
    req_a = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_sole_requester();
    test_voluntary_release();
    test_no_turnaround();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
